// File: rtl/key_frame_sampler.sv
// Purpose: synchronise, debounce and edge-detect push buttons, and latch presses once per video frame.
// Latency: key event visible DEBOUNCE_CYCLES+2 edges after the raw change; frame update 3 edges after VS fall.
// Backpressure: none; outputs are free-running registered pulses/levels with no handshake.
module key_frame_sampler #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic [N_KEYS-1:0] KEY,
    input  logic              VGA_VS,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] frame_press,
    output logic              frame_valid
);

    // Counter value at which a persistent mismatch is accepted as a new level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_KEYS-1:0] key_s1;
    logic [N_KEYS-1:0] key_s2;
    logic              vs_s1;
    logic              vs_s2;
    logic              vs_prev;
    logic [CNT_W-1:0]  cnt [N_KEYS];
    logic [N_KEYS-1:0] acc;
    logic              frame_boundary;

    // A frame closes on the falling edge of the synchronised (active-low) vertical sync.
    assign frame_boundary = vs_prev & ~vs_s2;

    // Two-flop synchronisers; reset to 1 so buttons read as released and VS as idle.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            key_s1  <= '1;
            key_s2  <= '1;
            vs_s1   <= 1'b1;
            vs_s2   <= 1'b1;
            vs_prev <= 1'b1;
        end else begin
            key_s1  <= KEY;
            key_s2  <= key_s1;
            vs_s1   <= VGA_VS;
            vs_s2   <= vs_s1;
            vs_prev <= vs_s2;
        end
    end

    // Per-channel debounce: a mismatch must persist DEBOUNCE_CYCLES edges before the level flips,
    // and the flip edge also raises exactly one press or release pulse.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            key_level   <= '0;
            key_press   <= '0;
            key_release <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                key_press[i]   <= 1'b0;
                key_release[i] <= 1'b0;
                if (~key_s2[i] == key_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    key_level[i]   <= ~key_s2[i];
                    cnt[i]         <= '0;
                    key_press[i]   <= ~key_s2[i];
                    key_release[i] <= key_s2[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Frame accumulator: a press coincident with the boundary is folded into the closing frame.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            acc         <= '0;
            frame_press <= '0;
            frame_valid <= 1'b0;
        end else if (frame_boundary) begin
            frame_press <= acc | key_press;
            acc         <= '0;
            frame_valid <= 1'b1;
        end else begin
            acc         <= acc | key_press;
            frame_valid <= 1'b0;
        end
    end

endmodule

// File: doc/key_frame_sampler.md
# key_frame_sampler

Parametrised input conditioner for the game's push-button channels. It synchronises the active-low `KEY` lines to `CLOCK_50`, debounces each channel and produces one-cycle press and release events. It also accumulates presses between VGA vertical-sync falling edges, so game logic sees one registered press vector per video frame. It sits between the board `KEY` pins / VGA controller `VGA_VS` and the game-state FSM in `toplevel`.

## Interface
- `N_KEYS`, default 4: number of independent button channels (≥1).
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a changed input must hold before it is accepted (≥1). The bench uses 4; the board build overrides it to 500000.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: width of the per-channel debounce counter.
- `CLOCK_50`  in  1  sole clock; all logic on rising edge.
- `RESET_N`  in  1  reset, synchronous, active-low.
- `KEY`  in  N_KEYS  raw buttons, asynchronous, active-low (0 = pressed).
- `VGA_VS`  in  1  vertical sync from the VGA controller, asynchronous to this block's logic, active-low.
- `key_level`  out  N_KEYS  debounced state, active-high (1 = held).
- `key_press`  out  N_KEYS  1-cycle pulse on each debounced press.
- `key_release`  out  N_KEYS  1-cycle pulse on each debounced release.
- `frame_press`  out  N_KEYS  presses accumulated over the last completed frame; held for a full frame.
- `frame_valid`  out  1  1-cycle pulse when `frame_press` updates.

## Operation
- **Synchronisers.** Each `KEY` bit and `VGA_VS` pass through two flops (`s1`, `s2`). Reset value is 1, meaning released / not in sync.
- **Debounce, per channel.**
  - State is `stable` (1 = pressed, compared against `~s2`) plus counter `cnt`.
  - If `~s2 == stable`: `cnt <= 0`.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`: `stable <= ~s2`, `cnt <= 0`, and a press or release pulse is raised on the same edge.
  - Otherwise: `cnt <= cnt+1`.
  - Any glitch shorter than `DEBOUNCE_CYCLES` consecutive mismatched cycles is discarded.
- **Outputs from the debounce stage.** `key_level = stable`, registered. `key_press` / `key_release` are registered pulses, high exactly one cycle per accepted transition. Press and release are never both high on one channel.
- **Frame boundary.** A boundary is the falling edge of the synchronised VS: previous `s2`=1, current `s2`=0.
- **Frame accumulator `acc`.** Each cycle `acc <= acc | key_press`.
  - On a boundary cycle: `frame_press <= acc | key_press`, `acc <= 0`, `frame_valid <= 1`.
  - A press pulse coincident with the boundary belongs to the closing frame.
- **Multiple presses.** Several presses of one channel within a frame collapse to one bit. A press held across frames appears only in the frame in which it was accepted.
- **Boundary with no presses.** `frame_press` becomes 0 and `frame_valid` still pulses.
- **No VS activity.** `acc` accumulates indefinitely. `frame_press` holds its last value.
- **Channel independence.** Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.

## Timing
- **Reset values.** While `RESET_N`=0 at an edge, every output is 0. `stable`, `cnt` and `acc` are 0; all synchroniser flops are 1.
- **Reset mid-operation.** Pending debounce counts and accumulated presses are discarded. No pulse is emitted in the reset cycle or the first cycle after it.
- **Key latency.** Raw `KEY` change first sampled at edge k:
  - `s2` changes at edge k+1.
  - `stable` and the pulse register update at edge k+1+`DEBOUNCE_CYCLES`.
  - The pulse is visible during the following cycle.
  - With `DEBOUNCE_CYCLES`=4 that is 5 edges.
- **Frame latency.** `VGA_VS` fall sampled at edge v: the boundary is detected at edge v+1. `frame_press` / `frame_valid` update at edge v+2.
- **Minimum input widths.** A key press must stay low ≥ `DEBOUNCE_CYCLES`+1 cycles to be guaranteed accepted. VS low and high phases must each be ≥2 cycles for every edge to be detected.

## Test plan
- **Reset.** Hold `RESET_N`=0 for 3 cycles with `KEY`=4'b0000 and `VGA_VS` toggling. Required: all outputs 0 throughout. `key_press`=4'b0000 during the cycle after release of reset.
- **Single press.** `KEY`=4'b1110 for 10 cycles, then 4'b1111. Required:
  - `key_press`=4'b0001 for exactly 1 cycle, 5 edges after the first sampling edge.
  - `key_level[0]` high.
  - `key_release`=4'b0001 pulse 5 edges after the release is sampled.
- **Glitch rejection.** `KEY`=4'b1101 for 3 cycles, then 4'b1111. Required: no pulse and `key_level` stays 0.
- **Frame accumulation.** Press keys 0 and 3 at different times, and key 3 twice, within one VS period; then drive a VS fall. Required:
  - `frame_press`=4'b1001 with `frame_valid` pulsing once.
  - At the next boundary with no presses: `frame_press`=4'b0000.
- **Coincident events.** Align a key-1 press pulse with the boundary cycle. Required: key 1 appears in the closing frame's `frame_press`, and `acc` is 0 afterwards.
- **Width scaling.** Instantiate `N_KEYS`=8, `DEBOUNCE_CYCLES`=1 and press all keys at once. Required: `key_press`=8'hFF for one cycle, 2 edges after sampling.
